// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 16-state encoding, IR capture pattern and DR selection codes.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SH_DR    = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SH_IR    = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  // Fixed pattern loaded into the IR shifter on Capture_IR (zero-extended).
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2,
    DR_SAMPLE = 2'd3
  } dr_sel_t;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// TAP port bundle. Sample-register signals exist only with JTAG_TAP_SAMPLE_EN defined.
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4
);
  import jtag_pkg::*;

  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  tap_state_t          tap_state;
  logic [IR_WIDTH-1:0] ir_value;
  logic                ext_sel;
  logic                ext_capture;
  logic                ext_shift;
  logic                ext_update;
  logic                ext_tdo;
`ifdef JTAG_TAP_SAMPLE_EN
  logic [7:0]          sample_in;
  logic [7:0]          sample_out;

  modport master (
    output TMS, TDI, ext_tdo, sample_in,
    input  TDO, TDO_EN, tap_state, ir_value, ext_sel, ext_capture, ext_shift, ext_update,
           sample_out
  );

  modport slave (
    input  TMS, TDI, ext_tdo, sample_in,
    output TDO, TDO_EN, tap_state, ir_value, ext_sel, ext_capture, ext_shift, ext_update,
           sample_out
  );
`else
  modport master (
    output TMS, TDI, ext_tdo,
    input  TDO, TDO_EN, tap_state, ir_value, ext_sel, ext_capture, ext_shift, ext_update
  );

  modport slave (
    input  TMS, TDI, ext_tdo,
    output TDO, TDO_EN, tap_state, ir_value, ext_sel, ext_capture, ext_shift, ext_update
  );
`endif

endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP state machine: registered state, combinational next state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t tap_state
);

  tap_state_t state, state_nxt;

  always_ff @(posedge TCLK) begin
    if (TRST) state <= TLR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = TMS ? TLR    : RTI;
      RTI:      state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR:   state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR:   state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = TMS ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  assign tap_state = state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: FSM, IR, BYPASS, IDCODE, external-DR strobes and TDO mux.
// Optional 8-bit SAMPLE register enabled by defining JTAG_TAP_SAMPLE_EN.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = '1
`ifdef JTAG_TAP_SAMPLE_EN
  ,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(4'b0011)
`endif
) (
  input  logic           TCLK,
  input  logic           TRST,
  jtag_tap_ctrl_if.slave jtag
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic                bypass_q;
  logic [31:0]         idcode_sr;
  dr_sel_t             dr_sel;
  logic                enter_tlr;
  logic                sample_bit;
  logic                tdo_c;

  // Any opcode that is not explicitly recognised falls back to BYPASS.
  function automatic dr_sel_t decode_dr(input logic [IR_WIDTH-1:0] ir);
    if (ir == OP_IDCODE) return DR_IDCODE;
    if (ir == OP_USER)   return DR_USER;
`ifdef JTAG_TAP_SAMPLE_EN
    if (ir == OP_SAMPLE) return DR_SAMPLE;
`endif
    if (ir == OP_BYPASS) return DR_BYPASS;
    return DR_BYPASS;
  endfunction

  jtag_tap_fsm u_fsm (
    .TCLK      (TCLK),
    .TRST      (TRST),
    .TMS       (jtag.TMS),
    .tap_state (state)
  );

  assign dr_sel    = decode_dr(ir_q);
  // Only TLR and Select-IR can move into TLR, so the IR reload lands on the entry edge.
  assign enter_tlr = jtag.TMS && ((state == TLR) || (state == SEL_IR));

  // Instruction register: shifter plus latched instruction
  always_ff @(posedge TCLK) begin
    if (TRST) begin
      ir_sr <= OP_IDCODE;
      ir_q  <= OP_IDCODE;
    end else begin
      case (state)
        CAP_IR:  ir_sr <= IR_WIDTH'(IR_CAPTURE);
        SH_IR:   ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
        default: ;
      endcase
      if (enter_tlr)            ir_q <= OP_IDCODE;
      else if (state == UPD_IR) ir_q <= ir_sr;
    end
  end

  // Built-in data registers; Exit/Pause states leave them untouched
  always_ff @(posedge TCLK) begin
    if (TRST) begin
      bypass_q  <= 1'b0;
      idcode_sr <= IDCODE_VAL;
    end else begin
      case (state)
        CAP_DR: begin
          bypass_q  <= 1'b0;
          idcode_sr <= IDCODE_VAL;
        end
        SH_DR: begin
          bypass_q  <= jtag.TDI;
          idcode_sr <= {jtag.TDI, idcode_sr[31:1]};
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_TAP_SAMPLE_EN
  logic [7:0] sample_sr;
  logic [7:0] sample_q;

  always_ff @(posedge TCLK) begin
    if (TRST) begin
      sample_sr <= 8'h00;
      sample_q  <= 8'h00;
    end else if (dr_sel == DR_SAMPLE) begin
      case (state)
        CAP_DR:  sample_sr <= jtag.sample_in;
        SH_DR:   sample_sr <= {jtag.TDI, sample_sr[7:1]};
        UPD_DR:  sample_q  <= sample_sr;
        default: ;
      endcase
    end
  end

  assign sample_bit      = sample_sr[0];
  assign jtag.sample_out = sample_q;
`else
  assign sample_bit = 1'b0;
`endif

  // Serial output mux
  always_comb begin
    tdo_c = 1'b0;
    if (state == SH_IR) begin
      tdo_c = ir_sr[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_IDCODE: tdo_c = idcode_sr[0];
        DR_USER:   tdo_c = jtag.ext_tdo;
        DR_SAMPLE: tdo_c = sample_bit;
        default:   tdo_c = bypass_q;
      endcase
    end
  end

  assign jtag.TDO         = tdo_c;
  assign jtag.TDO_EN      = is_shift_state(state);
  assign jtag.tap_state   = state;
  assign jtag.ir_value    = ir_q;
  assign jtag.ext_sel     = (ir_q == OP_USER);
  assign jtag.ext_capture = (state == CAP_DR) && jtag.ext_sel;
  assign jtag.ext_shift   = (state == SH_DR)  && jtag.ext_sel;
  assign jtag.ext_update  = (state == UPD_DR) && jtag.ext_sel;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: stimulus queues expected outputs, a monitor checks them.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  localparam int          IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;

  typedef enum int {K_STATE, K_IR, K_TDO, K_TDOEN, K_SEL, K_CAP, K_SHIFT, K_UPD} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  logic        TCLK = 1'b0;
  logic        TRST = 1'b1;
  logic        final_chk = 1'b0;
  logic        final_done = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  jtag_tap_ctrl_if #(.IR_WIDTH(IRW)) jif ();

  jtag_tap_ctrl #(
    .IR_WIDTH   (IRW),
    .IDCODE_VAL (IDV),
    .OP_IDCODE  (4'b0001),
    .OP_USER    (4'b0010),
    .OP_BYPASS  (4'b1111)
  ) dut (
    .TCLK (TCLK),
    .TRST (TRST),
    .jtag (jif.slave)
  );

  always #5 TCLK = ~TCLK;
  always @(posedge TCLK) cyc_cnt <= cyc_cnt + 1;

  function automatic string kname(input kind_t k);
    case (k)
      K_STATE: return "tap_state";
      K_IR:    return "ir_value";
      K_TDO:   return "TDO";
      K_TDOEN: return "TDO_EN";
      K_SEL:   return "ext_sel";
      K_CAP:   return "ext_capture";
      K_SHIFT: return "ext_shift";
      default: return "ext_update";
    endcase
  endfunction

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_STATE: return 32'(jif.tap_state);
      K_IR:    return 32'(jif.ir_value);
      K_TDO:   return 32'(jif.TDO);
      K_TDOEN: return 32'(jif.TDO_EN);
      K_SEL:   return 32'(jif.ext_sel);
      K_CAP:   return 32'(jif.ext_capture);
      K_SHIFT: return 32'(jif.ext_shift);
      default: return 32'(jif.ext_update);
    endcase
  endfunction

  // Monitor: compares queued expectations against outputs away from the rising edge
  always @(negedge TCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.kind);
      checks++;
      if (mon_e.cyc != cyc_cnt || mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h, expected %h", kname(mon_e.kind), mon_e.cyc,
                 mon_act, mon_e.exp);
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
    end
  end

  task automatic step(input logic tms, input logic tdi);
    jif.TMS = tms;
    jif.TDI = tdi;
    @(posedge TCLK);
    #1;
  endtask

  task automatic expect_v(input kind_t k, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // RTI -> IR scan of v (LSB first) -> RTI
  task automatic load_ir(input logic [IRW-1:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) step(i == IRW - 1, v[i]);
    step(1'b1, 1'b0);
    expect_v(K_STATE, 32'(UPD_IR));
    step(1'b0, 1'b0);
    expect_v(K_IR, 32'(v));
  endtask

  // RTI -> ShDR, shift TDI 1,0,1 through a 1-bit register expecting 0,1,0,1, back to RTI
  task automatic bypass_scan();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(SH_DR));
    expect_v(K_TDO, 32'd0);
    expect_v(K_SHIFT, 32'd0);
    step(1'b0, 1'b1); expect_v(K_TDO, 32'd1);
    step(1'b0, 1'b0); expect_v(K_TDO, 32'd0);
    step(1'b0, 1'b1); expect_v(K_TDO, 32'd1);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    expect_v(K_UPD, 32'd0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    jif.TMS     = 1'b1;
    jif.TDI     = 1'b0;
    jif.ext_tdo = 1'b0;
`ifdef JTAG_TAP_SAMPLE_EN
    jif.sample_in = 8'h00;
`endif

    // Reset, then into Run-Test/Idle
    TRST = 1'b1;
    step(1'b1, 1'b0);
    expect_v(K_STATE, 32'(TLR));
    expect_v(K_IR, 32'h1);
    expect_v(K_TDO, 32'd0);
    expect_v(K_TDOEN, 32'd0);
    TRST = 1'b0;
    step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(RTI));
    expect_v(K_IR, 32'h1);

    // IDCODE scan with a Pause detour after 16 bits
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(SH_DR));
    expect_v(K_TDOEN, 32'd1);
    for (int i = 0; i < 32; i++) begin
      expect_v(K_TDO, 32'(IDV[i]));
      if (i == 15) begin
        step(1'b1, 1'b0);
        expect_v(K_STATE, 32'(EX1_DR));
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        expect_v(K_STATE, 32'(PAUSE_DR));
        expect_v(K_TDOEN, 32'd0);
        expect_v(K_TDO, 32'd0);
        step(1'b1, 1'b0);
        expect_v(K_STATE, 32'(EX2_DR));
        step(1'b0, 1'b0);
        expect_v(K_STATE, 32'(SH_DR));
      end else begin
        step(i == 31, 1'b0);
      end
    end
    expect_v(K_STATE, 32'(EX1_DR));
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(RTI));

    // IR scan: capture pattern appears first, then all-ones latched
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(SH_IR));
    expect_v(K_TDOEN, 32'd1);
    expect_v(K_TDO, 32'd1);
    step(1'b0, 1'b1); expect_v(K_TDO, 32'd0);
    step(1'b0, 1'b1); expect_v(K_TDO, 32'd0);
    step(1'b0, 1'b1); expect_v(K_TDO, 32'd0);
    step(1'b1, 1'b1);
    expect_v(K_STATE, 32'(EX1_IR));
    expect_v(K_IR, 32'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    expect_v(K_IR, 32'hF);
    bypass_scan();

    // Undefined opcode behaves as BYPASS
    load_ir(4'h5);
    bypass_scan();

    // External user DR: strobes, TDO passthrough, pause and resume
    load_ir(4'b0010);
    expect_v(K_SEL, 32'd1);
    step(1'b1, 1'b0);
    expect_v(K_CAP, 32'd0);
    step(1'b0, 1'b0);
    expect_v(K_CAP, 32'd1);
    expect_v(K_SHIFT, 32'd0);
    step(1'b0, 1'b0);
    jif.ext_tdo = 1'b1;
    expect_v(K_CAP, 32'd0);
    expect_v(K_SHIFT, 32'd1);
    expect_v(K_TDO, 32'd1);
    step(1'b0, 1'b0);
    jif.ext_tdo = 1'b0;
    expect_v(K_SHIFT, 32'd1);
    expect_v(K_TDO, 32'd0);
    step(1'b0, 1'b0);
    jif.ext_tdo = 1'b1;
    expect_v(K_SHIFT, 32'd1);
    expect_v(K_TDO, 32'd1);
    step(1'b1, 1'b0);
    expect_v(K_SHIFT, 32'd0);
    expect_v(K_TDO, 32'd0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(PAUSE_DR));
    expect_v(K_SHIFT, 32'd0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    expect_v(K_SHIFT, 32'd1);
    expect_v(K_TDO, 32'd1);
    step(1'b1, 1'b0);
    expect_v(K_UPD, 32'd0);
    step(1'b1, 1'b0);
    expect_v(K_STATE, 32'(UPD_DR));
    expect_v(K_UPD, 32'd1);
    step(1'b0, 1'b0);
    expect_v(K_UPD, 32'd0);
    jif.ext_tdo = 1'b0;

    // Five TMS=1 cycles from Shift-DR reach TLR; IR reloads on the fifth edge
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(SH_DR));
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    expect_v(K_STATE, 32'(SEL_IR));
    expect_v(K_IR, 32'h2);
    step(1'b1, 1'b0);
    expect_v(K_STATE, 32'(TLR));
    expect_v(K_IR, 32'h1);
    expect_v(K_SEL, 32'd0);

    // Reset in the middle of an IR shift
    step(1'b0, 1'b0);
    load_ir(4'hF);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(SH_IR));
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    TRST = 1'b1;
    step(1'b0, 1'b1);
    expect_v(K_STATE, 32'(TLR));
    expect_v(K_IR, 32'h1);
    expect_v(K_TDO, 32'd0);
    expect_v(K_TDOEN, 32'd0);
    TRST = 1'b0;
    step(1'b0, 1'b0);
    expect_v(K_STATE, 32'(RTI));

    step(1'b0, 1'b0);
    final_chk = 1'b1;
    for (int w = 0; w < 20 && !final_done; w++) @(posedge TCLK);
    #1;
    if (!final_done) begin
      $display("FAIL monitor_timeout: got no drain check, expected one");
      $fatal(1, "monitor did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
